// File: rtl/xor_txn_sequencer.sv
// xor_txn_sequencer: bus-side master for the XOR FIFO block.
// For each accepted operand pair it writes A and then B, polls the
// Y-not-empty status, pops Y and returns it on the output stream.
// Only one transaction is in flight at a time.
// Optional build macro XOR_SEQ_CHECK_EN adds a checker. The checker compares
// each popped Y against a^b and exposes chk_mismatch and mismatch_cnt.
module xor_txn_sequencer #(
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned A_ADDR       = 4,
  parameter int unsigned B_ADDR       = 5,
  parameter int unsigned STAT_ADDR    = 2,
  parameter int unsigned Y_ADDR       = 3,
  parameter int unsigned POLL_TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_a,
  input  logic              in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_y,
  output logic              out_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_address,
  output logic              wr_data,
  input  logic              wr_rdy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_address,
  input  logic              rd_data,
  input  logic              rd_rdy,
`ifdef XOR_SEQ_CHECK_EN
  output logic              chk_mismatch,
  output logic [7:0]        mismatch_cnt,
`endif
  output logic              busy
);

  localparam logic [ADDR_W-1:0] A_AD    = A_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] B_AD    = B_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] STAT_AD = STAT_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] Y_AD    = Y_ADDR[ADDR_W-1:0];
  localparam logic [15:0]       TO      = POLL_TIMEOUT[15:0];

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, POLL, RD_Y, RESP} state_t;

  state_t      state;
  logic [15:0] poll_cnt;
  logic        op_b;
`ifdef XOR_SEQ_CHECK_EN
  logic        op_a;
`endif

  // Transaction FSM. Every output is registered here. Each DUT address or
  // data change happens only on the edge where the current request completes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      poll_cnt   <= '0;
      op_b       <= 1'b0;
`ifdef XOR_SEQ_CHECK_EN
      op_a       <= 1'b0;
`endif
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_y      <= 1'b0;
      out_err    <= 1'b0;
      wr_en      <= 1'b0;
      wr_address <= '0;
      wr_data    <= 1'b0;
      rd_en      <= 1'b0;
      rd_address <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_b       <= in_b;
`ifdef XOR_SEQ_CHECK_EN
          op_a       <= in_a;
`endif
          in_ready   <= 1'b0;
          busy       <= 1'b1;
          wr_en      <= 1'b1;
          wr_address <= A_AD;
          wr_data    <= in_a;
          state      <= WR_A;
        end
        WR_A: if (wr_rdy) begin
          wr_address <= B_AD;
          wr_data    <= op_b;
          state      <= WR_B;
        end
        WR_B: if (wr_rdy) begin
          wr_en      <= 1'b0;
          rd_en      <= 1'b1;
          rd_address <= STAT_AD;
          poll_cnt   <= '0;
          state      <= POLL;
        end
        POLL: if (rd_rdy) begin
          if (rd_data) begin
            rd_address <= Y_AD;
            state      <= RD_Y;
          end else begin
            poll_cnt <= poll_cnt + 16'd1;
            // Give up after the poll budget. The operands stay queued in the DUT.
            if (poll_cnt + 16'd1 == TO) begin
              rd_en     <= 1'b0;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_y     <= 1'b0;
              state     <= RESP;
            end
          end
        end
        RD_Y: if (rd_rdy) begin
          rd_en     <= 1'b0;
          out_y     <= rd_data;
          out_err   <= 1'b0;
          out_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef XOR_SEQ_CHECK_EN
  // Result checker: compare the popped Y against a^b and count mismatches
  // with saturation. Timeout aborts never reach RD_Y, so they are not compared.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      chk_mismatch <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      chk_mismatch <= 1'b0;
      if (state == RD_Y && rd_rdy && rd_data != (op_a ^ op_b)) begin
        chk_mismatch <= 1'b1;
        if (mismatch_cnt != 8'hFF) mismatch_cnt <= mismatch_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_xor_txn_sequencer.sv
// Directed bench for xor_txn_sequencer with a small XOR FIFO model on the bus side.
module tb_xor_txn_sequencer;

  logic CLK = 0, RST = 0;
  logic in_valid = 0, in_a = 0, in_b = 0, out_ready = 0, wr_rdy = 1, rd_rdy = 1;
  logic in_ready, out_valid, out_y, out_err, wr_en, wr_data, rd_en, rd_data, busy;
  logic [2:0] wr_address, rd_address;
`ifdef XOR_SEQ_CHECK_EN
  logic chk_mismatch;
  logic [7:0] mismatch_cnt;
  int mm_pulses = 0;
`endif

  int n_chk = 0, n_fail = 0;

  xor_txn_sequencer #(.POLL_TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_err(out_err),
    .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .rd_en(rd_en), .rd_address(rd_address), .rd_data(rd_data), .rd_rdy(rd_rdy),
`ifdef XOR_SEQ_CHECK_EN
    .chk_mismatch(chk_mismatch), .mismatch_cnt(mismatch_cnt),
`endif
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // XOR FIFO model: A/B queues, status = both non-empty, Y = a^b (optionally corrupted).
  logic mem_a [16];
  logic mem_b [16];
  logic [3:0] wlog [16];
  int wa = 0, wb = 0, rp = 0, wn = 0, stat_reads = 0;
  logic stat_stuck = 0, inv11 = 0, mdl_clr = 0, overlap = 0, y_avail, ya, yb;

  always_comb begin
    y_avail = (wa > rp) && (wb > rp);
    ya = mem_a[rp[3:0]];
    yb = mem_b[rp[3:0]];
    rd_data = 1'b0;
    if (rd_address == 3'd2) rd_data = y_avail && !stat_stuck;
    else if (rd_address == 3'd3 && y_avail) rd_data = (ya ^ yb) ^ (inv11 && ya && yb);
  end

  always @(posedge CLK) begin
    if (mdl_clr) begin
      wa <= 0; wb <= 0; rp <= 0; wn <= 0; stat_reads <= 0;
    end else begin
      if (wr_en && wr_rdy) begin
        wlog[wn[3:0]] <= {wr_address, wr_data};
        wn <= wn + 1;
        if (wr_address == 3'd4) begin mem_a[wa[3:0]] <= wr_data; wa <= wa + 1; end
        else if (wr_address == 3'd5) begin mem_b[wb[3:0]] <= wr_data; wb <= wb + 1; end
      end
      if (rd_en && rd_rdy && rd_address == 3'd3) rp <= rp + 1;
      if (rd_en && rd_rdy && rd_address == 3'd2) stat_reads <= stat_reads + 1;
    end
  end

  always @(negedge CLK) begin
    if (wr_en && rd_en) overlap <= 1'b1;
`ifdef XOR_SEQ_CHECK_EN
    if (chk_mismatch) mm_pulses <= mm_pulses + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {in_ready,out_valid,out_y,out_err,wr_en,wr_data,rd_en,busy,wr_address,rd_address}
  task automatic chk_rst(input string tag);
    chk(tag, {in_ready, out_valid, out_y, out_err, wr_en, wr_data, rd_en, busy,
              wr_address, rd_address}, 14'b1000_0000_000_000);
  endtask

  task automatic clr_model();
    @(negedge CLK); mdl_clr = 1;
    @(posedge CLK); #1 mdl_clr = 0;
  endtask

  task automatic send_pair(input logic a, input logic b);
    @(negedge CLK);
    in_valid = 1; in_a = a; in_b = b;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) break;
      @(negedge CLK);
    end
    chk("accept_ready", in_ready, 1);
    @(posedge CLK);
    #1 in_valid = 0;
  endtask

  // k counts edges starting with the accept edge; returns at the negedge where out_valid=1
  task automatic wait_resp(output int k);
    k = 1;
    while (k < 100) begin
      @(negedge CLK);
      if (out_valid) break;
      @(posedge CLK);
      k++;
    end
    chk("resp_arrives", out_valid, 1);
  endtask

  task automatic consume();
    out_ready = 1;
    @(posedge CLK);
    #1 out_ready = 0;
    chk("consume_state", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [1:0] av [4];
    logic [1:0] bv [4];
    logic yv [4];
    logic [3:0] w0, w1;
    av = '{2'd0, 2'd0, 2'd1, 2'd1};
    bv = '{2'd0, 2'd1, 2'd0, 2'd1};
    yv = '{1'b0, 1'b1, 1'b1, 1'b0};

    #2 RST = 1;
    repeat (3) @(negedge CLK);
    chk_rst("reset_state");
`ifdef XOR_SEQ_CHECK_EN
    chk("reset_mcnt", {chk_mismatch, mismatch_cnt}, 0);
`endif
    RST = 0;
    clr_model();

    // single pair a=1 b=0
    send_pair(1, 0);
    wait_resp(k);
    chk("single_latency", k, 5);
    chk("single_y_err", {out_y, out_err}, 2'b10);
    consume();
    w0 = wlog[0];
    w1 = wlog[1];
    chk("single_wr0", w0, {3'd4, 1'b1});
    chk("single_wr1", w1, {3'd5, 1'b0});
    chk("single_wrcount", wn, 2);

    // all four combos back-to-back
    for (int i = 0; i < 4; i++) begin
      send_pair(av[i][0], bv[i][0]);
      wait_resp(k);
      chk("combo_y_err", {out_y, out_err}, {yv[i], 1'b0});
      consume();
    end

    // write backpressure during WR_A
    wr_rdy = 0;
    send_pair(1, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("wstall_hold", {wr_en, wr_address, rd_en}, {1'b1, 3'd4, 1'b0});
    end
    wr_rdy = 1;
    @(posedge CLK);
    #1 chk("wstall_to_b", {wr_en, wr_address, wr_data}, {1'b1, 3'd5, 1'b1});
    wait_resp(k);
    chk("wstall_y", {out_y, out_err}, 2'b00);
    consume();

    // poll timeout with status stuck at 0
    clr_model();
    stat_stuck = 1;
    send_pair(1, 0);
    wait_resp(k);
    chk("timeout_polls", stat_reads, 4);
    chk("timeout_y_err", {out_y, out_err, rd_en}, 3'b010);
    consume();
    stat_stuck = 0;
    clr_model();

    // output backpressure in RESP
    send_pair(0, 1);
    wait_resp(k);
    for (int i = 0; i < 6; i++) begin
      chk("resp_hold", {out_valid, out_y, out_err, in_ready}, 4'b1100);
      @(negedge CLK);
    end
    consume();

    // async reset while polling
    stat_stuck = 1;
    send_pair(1, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (rd_en && rd_address == 3'd2) break;
    end
    chk("reach_poll", {rd_en, rd_address}, {1'b1, 3'd2});
    RST = 1;
    #1 chk_rst("async_reset");
    @(negedge CLK);
    RST = 0;
    stat_stuck = 0;
    clr_model();
    send_pair(1, 0);
    wait_resp(k);
    chk("post_reset_y", {out_y, out_err}, 2'b10);
    consume();

`ifdef XOR_SEQ_CHECK_EN
    inv11 = 1;
    clr_model();
    send_pair(1, 1);
    wait_resp(k);
    chk("inv_y", {out_y, out_err}, 2'b10);
    consume();
    @(negedge CLK);
    chk("mm_pulses", mm_pulses, 1);
    chk("mm_cnt", mismatch_cnt, 1);
    inv11 = 0;
`endif

    chk("no_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
